fetch_unit: RTL and testbench

Instruction fetch front-end that produces the 32-bit instruction stream consumed by the RV32I decoder. It holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel. In-order responses are buffered in a small FIFO, and each instruction is handed to decode with its PC over a valid/ready handshake. Branch/jump redirects flush buffered and in-flight instructions.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_sync_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   NOP_INSTR        : word shown to decode while the instruction buffer is empty
//   DEFAULT_RESET_PC : default fetch address after reset
//   fetch_entry_t    : one instruction buffer entry, {pc, instr}
//   ptr_width()      : pointer width for a buffer of the given depth (minimum 1)
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with a combinational head read and a synchronous flush.
// DEPTH must be a power of two so that the pointers wrap naturally.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empty the FIFO; takes priority over push and pop
//   push       : write push_data at the tail
//   push_data  : WIDTH-bit entry to write
//   pop        : drop the head entry
//   head       : current head entry (stale when empty)
//   full/empty : occupancy flags
//   count      : number of entries held, 0..DEPTH
module fetch_unit_sync_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic                        full,
    output logic                        empty,
    output logic [ptr_width(DEPTH):0]   count
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == DEPTH_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end for the RV32I decoder. Issues word fetches on a
// valid/ready request channel, buffers in-order responses together with their
// PC, and hands them to decode over a valid/ready handshake. A redirect flushes
// buffered instructions and marks in-flight fetches for discard.
//   clk, rst_n       : clock, asynchronous active-low reset
//   imem_req_valid   : fetch request valid
//   imem_req_ready   : memory accepts request
//   imem_req_addr    : word-aligned fetch address
//   imem_rsp_valid   : response valid (in order, no backpressure)
//   imem_rsp_data    : fetched instruction word
//   instr_valid      : instruction available to decode
//   instr_ready      : decoder consumes instruction
//   instr, instr_pc  : instruction word and its address
//   redirect_valid   : taken branch/jump, one-cycle pulse
//   redirect_pc      : new fetch target
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int          PW        = ptr_width(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic          req_en;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    fetch_entry_t  buf_head;
    fetch_entry_t  buf_push_data;
    logic          buf_empty;
    logic          buf_full;
    logic [CW-1:0] buf_count;

    logic [31:0]   pcq_head;
    logic          pcq_empty;
    logic          pcq_full;
    logic [CW-1:0] pcq_count;

    logic          req_fire;
    logic          rsp_keep;
    logic          instr_pop;
    logic [CW:0]   occupancy;
    logic [CW:0]   discard_calc;
    logic [CW-1:0] discard_sat;

    // Credits cover both in-flight and buffered words, so a response always
    // finds room in the buffer. req_en keeps the request low for the first
    // cycle after reset release.
    assign occupancy      = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = req_en & (occupancy < DEPTH_EXT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_keep       = imem_rsp_valid & (discard == '0) & ~redirect_valid;

    assign instr_valid    = ~buf_empty & ~redirect_valid;
    assign instr          = buf_empty ? NOP_INSTR : buf_head.instr;
    assign instr_pc       = buf_empty ? 32'h0 : buf_head.pc;
    assign instr_pop      = instr_valid & instr_ready;

    assign buf_push_data  = '{pc: pcq_head, instr: imem_rsp_data};

    // Everything still owed by memory after this cycle is stale once redirected.
    assign discard_calc = {1'b0, outstanding} + (CW + 1)'(req_fire) - (CW + 1)'(imem_rsp_valid);
    assign discard_sat  = (discard_calc > DEPTH_EXT) ? DEPTH_EXT[CW-1:0] : discard_calc[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            req_en      <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            req_en <= 1'b1;

            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                discard  <= discard_sat;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    fetch_unit_sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (buf_push_data),
        .pop       (instr_pop),
        .head      (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // PCs of live (non-discarded) requests, matched to responses in order.
    fetch_unit_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    a_buf_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        rsp_keep |-> (!buf_full && !pcq_empty));
    a_pcq_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        (req_fire && !redirect_valid) |-> !pcq_full);
    a_pcq_bounded     : assert property (@(posedge clk) disable iff (!rst_n)
        pcq_count <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_q[$];
    logic        mem_hold = 1'b0;
    logic [31:0] del_pc[$];
    logic [31:0] del_instr[$];
    int          fires_cnt = 0;
    int          pops_cnt  = 0;
    int          max_occ   = 0;
    int          base;
    int          breaks;

    initial forever #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_req_valid"},   32'(imem_req_valid), 32'h0);
        check_eq({pfx, "_req_addr"},    imem_req_addr,       32'h0000_0000);
        check_eq({pfx, "_instr_valid"}, 32'(instr_valid),    32'h0);
        check_eq({pfx, "_instr"},       instr,               32'h0000_0013);
        check_eq({pfx, "_instr_pc"},    instr_pc,            32'h0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drain();
        imem_req_ready = 1'b0;
        repeat (6) step();
    endtask

    // Memory model (1-cycle latency, data = addr>>2, optional hold) and
    // delivery monitor. Inputs are driven just after the falling edge;
    // handshakes are sampled once everything has settled.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
                fires_cnt      = 0;
                pops_cnt       = 0;
            end else begin
                if (!mem_hold && mem_q.size() > 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_q.pop_front();
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = 32'hDEAD_BEEF;
                end
                #1;
                if (imem_req_valid && imem_req_ready) begin
                    mem_q.push_back(imem_req_addr >> 2);
                    fires_cnt++;
                end
                if (instr_valid && instr_ready) begin
                    del_pc.push_back(instr_pc);
                    del_instr.push_back(instr);
                    pops_cnt++;
                end
                if (fires_cnt - pops_cnt > max_occ) max_occ = fires_cnt - pops_cnt;
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state and first-fetch latency
        #12;
        check_reset_outputs("rst");
        step(); #3; rst_n = 1'b1;
        step(); #3;
        check_eq("c1_req_valid",   32'(imem_req_valid), 32'h1);
        check_eq("c1_instr_valid", 32'(instr_valid),    32'h0);
        step(); #3;
        check_eq("c2_instr_valid", 32'(instr_valid),    32'h0);
        step(); #3;
        check_eq("c3_instr_valid", 32'(instr_valid),    32'h1);
        check_eq("c3_instr_pc",    instr_pc,            32'h0);
        repeat (8) step(); #3;
        check_eq("seq_count_ge4", 32'(del_pc.size() >= 4), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("seq_pc%0d", i),    del_pc[i],    32'(4 * i));
            check_eq($sformatf("seq_instr%0d", i), del_instr[i], 32'(i));
        end

        // Decoder stall: credit limit, then lossless resume
        step();
        max_occ     = 0;
        instr_ready = 1'b0;
        repeat (10) step(); #3;
        check_eq("stall_req_valid",   32'(imem_req_valid), 32'h0);
        check_eq("stall_instr_valid", 32'(instr_valid),    32'h1);
        check_eq("stall_max_occ",     32'(max_occ),        32'h2);
        step();
        instr_ready = 1'b1;
        repeat (10) step();
        drain(); #3;
        check_eq("stall_no_loss", 32'(del_pc.size()), 32'(fires_cnt));
        breaks = 0;
        for (int i = 0; i < del_pc.size(); i++) begin
            if (del_pc[i] != 32'(4 * i) || del_instr[i] != 32'(i)) breaks++;
        end
        check_eq("stall_contig", 32'(breaks), 32'h0);

        // Redirect with two requests in flight
        step();
        base = fires_cnt;
        del_pc.delete();
        del_instr.delete();
        mem_hold       = 1'b1;
        imem_req_ready = 1'b1;
        repeat (4) step(); #3;
        check_eq("rd1_req_valid", 32'(imem_req_valid), 32'h0);
        check_eq("rd1_inflight",  32'(fires_cnt - base), 32'h2);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #3;
        check_eq("rd1_instr_valid", 32'(instr_valid), 32'h0);
        step();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        repeat (10) step();
        drain(); #3;
        check_eq("rd1_count",  32'(del_pc.size()), 32'(fires_cnt - base - 2));
        check_eq("rd1_pc0",    del_pc[0],    32'h0000_0100);
        check_eq("rd1_instr0", del_instr[0], 32'h0000_0040);
        check_eq("rd1_pc1",    del_pc[1],    32'h0000_0104);

        // Redirect coinciding with a response and a request handshake
        step();
        base = fires_cnt;
        del_pc.delete();
        del_instr.delete();
        imem_req_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #3;
        check_eq("rd2_fire_in_redirect", 32'(imem_req_valid), 32'h1);
        check_eq("rd2_instr_valid",      32'(instr_valid),    32'h0);
        step();
        redirect_valid = 1'b0;
        repeat (8) step();
        drain(); #3;
        check_eq("rd2_count",  32'(del_pc.size()), 32'(fires_cnt - base - 2));
        check_eq("rd2_pc0",    del_pc[0],    32'h0000_0200);
        check_eq("rd2_instr0", del_instr[0], 32'h0000_0080);

        // Address wrap past 0xFFFF_FFFC, misaligned target bits cleared
        step();
        del_pc.delete();
        del_instr.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFA;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #3;
        check_eq("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
        repeat (10) step(); #3;
        check_eq("wrap_count_ge3", 32'(del_pc.size() >= 3), 32'h1);
        check_eq("wrap_pc1",    del_pc[1],    32'hFFFF_FFFC);
        check_eq("wrap_instr1", del_instr[1], 32'h3FFF_FFFF);
        check_eq("wrap_pc2",    del_pc[2],    32'h0000_0000);
        check_eq("wrap_instr2", del_instr[2], 32'h0000_0000);

        // Redirect while the buffer is full: valid forced low, buffer refills from target
        step();
        instr_ready = 1'b0;
        repeat (6) step(); #3;
        check_eq("full_instr_valid", 32'(instr_valid),    32'h1);
        check_eq("full_req_valid",   32'(imem_req_valid), 32'h0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        instr_ready    = 1'b1;
        #3;
        check_eq("rd3_instr_valid", 32'(instr_valid), 32'h0);
        step();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        repeat (6) step(); #3;
        check_eq("rd3_instr_valid_after", 32'(instr_valid), 32'h1);
        check_eq("rd3_head_pc",    instr_pc, 32'h0000_0300);
        check_eq("rd3_head_instr", instr,    32'h0000_00C0);

        // Asynchronous reset with a full buffer, then restart from RESET_PC
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        step(); #3;
        rst_n = 1'b1;
        del_pc.delete();
        del_instr.delete();
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        repeat (8) step(); #3;
        check_eq("restart_count_ge2", 32'(del_pc.size() >= 2), 32'h1);
        check_eq("restart_pc0",    del_pc[0],    32'h0000_0000);
        check_eq("restart_instr0", del_instr[0], 32'h0000_0000);
        check_eq("restart_pc1",    del_pc[1],    32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
